// File: rtl/barrel_pkg.sv
// ============================================================================
//  Module   : barrel_pkg
//  Purpose  : Operation codes and op-class helpers shared by the barrel shifter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package barrel_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ROL = 3'd0,
        OP_ROR = 3'd1,
        OP_SLL = 3'd2,
        OP_SRL = 3'd3,
        OP_SRA = 3'd4
    } barrel_op_e;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return op <= OP_SRA;
    endfunction

    // Right-direction ops run through the left-shift core on a bit-reversed operand.
    function automatic logic op_is_right(input logic [OP_W-1:0] op);
        return (op == OP_ROR) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic logic op_is_rotate(input logic [OP_W-1:0] op);
        return (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/barrel_stage.sv
// ============================================================================
//  Module   : barrel_stage
//  Purpose  : One registered left-shift stage; shifts by 2^STAGE when selected.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module barrel_stage
    import barrel_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STAGE = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       up_valid,
    input  logic [WIDTH-1:0]           up_data,
    input  logic [$clog2(WIDTH)-1:0]   up_amnt,
    input  logic [OP_W-1:0]            up_op,
    input  logic                       up_fill,
    input  logic                       up_err,
    output logic                       dn_valid,
    output logic [WIDTH-1:0]           dn_data,
    output logic [$clog2(WIDTH)-1:0]   dn_amnt,
    output logic [OP_W-1:0]            dn_op,
    output logic                       dn_fill,
    output logic                       dn_err
);

    localparam int c_shift = 1 << STAGE;

    logic [WIDTH-1:0] w_shifted;

    always_comb begin
        w_shifted = up_data;
        if (up_amnt[STAGE] && !up_err) begin
            if (op_is_rotate(up_op)) begin
                w_shifted = {up_data[WIDTH-1-c_shift:0], up_data[WIDTH-1 -: c_shift]};
            end else begin
                w_shifted = {up_data[WIDTH-1-c_shift:0], {c_shift{up_fill}}};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
            dn_amnt  <= '0;
            dn_op    <= '0;
            dn_fill  <= 1'b0;
            dn_err   <= 1'b0;
        end else if (en) begin
            dn_valid <= up_valid;
            dn_data  <= w_shifted;
            dn_amnt  <= up_amnt;
            dn_op    <= up_op;
            dn_fill  <= up_fill;
            dn_err   <= up_err;
        end
    end

endmodule

`default_nettype wire

// File: rtl/barrel_shifter_pipe.sv
// ============================================================================
//  Module   : barrel_shifter_pipe
//  Purpose  : log2(WIDTH)-stage pipelined rotate/shift unit with valid/ready flow.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module barrel_shifter_pipe
    import barrel_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH)-1:0]   in_amnt,
    input  logic [OP_W-1:0]            in_op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_zero,
    output logic                       out_err
);

    localparam int SHW = $clog2(WIDTH);

    logic                 w_valid [0:SHW];
    logic [WIDTH-1:0]     w_data  [0:SHW];
    logic [SHW-1:0]       w_amnt  [0:SHW];
    logic [OP_W-1:0]      w_op    [0:SHW];
    logic                 w_fill  [0:SHW];
    logic                 w_err   [0:SHW];
    logic [WIDTH-1:0]     w_in_rev;
    logic [WIDTH-1:0]     w_out_rev;
    logic                 w_unused;

    for (genvar b = 0; b < WIDTH; b++) begin : g_rev
        assign w_in_rev[b]  = in_data[WIDTH-1-b];
        assign w_out_rev[b] = w_data[SHW][WIDTH-1-b];
    end

    // A single enable stalls the whole pipe only when a result is stuck at the output.
    assign in_ready   = !out_valid || out_ready;

    assign w_valid[0] = in_valid && in_ready;
    assign w_data[0]  = op_is_right(in_op) ? w_in_rev : in_data;
    assign w_amnt[0]  = in_amnt;
    assign w_op[0]    = in_op;
    assign w_fill[0]  = (in_op == OP_SRA) && in_data[WIDTH-1];
    assign w_err[0]   = !op_is_legal(in_op);

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        barrel_stage #(
            .WIDTH (WIDTH),
            .STAGE (k)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (in_ready),
            .up_valid (w_valid[k]),
            .up_data  (w_data[k]),
            .up_amnt  (w_amnt[k]),
            .up_op    (w_op[k]),
            .up_fill  (w_fill[k]),
            .up_err   (w_err[k]),
            .dn_valid (w_valid[k+1]),
            .dn_data  (w_data[k+1]),
            .dn_amnt  (w_amnt[k+1]),
            .dn_op    (w_op[k+1]),
            .dn_fill  (w_fill[k+1]),
            .dn_err   (w_err[k+1])
        );
    end

    assign out_valid = w_valid[SHW];
    assign out_err   = w_err[SHW];
    assign out_data  = op_is_right(w_op[SHW]) ? w_out_rev : w_data[SHW];
    assign out_zero  = (w_data[SHW] == '0);
    assign w_unused  = ^{w_amnt[SHW], w_fill[SHW]};

endmodule

`default_nettype wire

// File: tb/tb_barrel_shifter_pipe.sv
// ============================================================================
//  Module   : tb_barrel_shifter_pipe
//  Purpose  : Self-checking bench for barrel_shifter_pipe at WIDTH 32, 8 and 64.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_barrel_shifter_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_zero, a_out_err;
    logic [31:0] a_in_data, a_out_data;
    logic [4:0]  a_in_amnt;
    logic [2:0]  a_in_op;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_zero, b_out_err;
    logic [7:0]  b_in_data, b_out_data;
    logic [2:0]  b_in_amnt;
    logic [2:0]  b_in_op;

    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_zero, c_out_err;
    logic [63:0] c_in_data, c_out_data;
    logic [5:0]  c_in_amnt;
    logic [2:0]  c_in_op;

    int n_vec = 0;
    int n_err = 0;

    barrel_shifter_pipe #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_amnt(a_in_amnt), .in_op(a_in_op),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_zero(a_out_zero), .out_err(a_out_err));

    barrel_shifter_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_amnt(b_in_amnt), .in_op(b_in_op),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_zero(b_out_zero), .out_err(b_out_err));

    barrel_shifter_pipe #(.WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_amnt(c_in_amnt), .in_op(c_in_op),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_zero(c_out_zero), .out_err(c_out_err));

    // Reference: {err, result} from plain shift arithmetic at width w.
    function automatic logic [64:0] ref_op(input logic [63:0] d_in, input int a,
                                           input logic [2:0] op, input int w);
        logic [63:0]        mask, d, r;
        logic signed [63:0] s;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        d    = d_in & mask;
        case (op)
            3'd0: r = (d << a) | (d >> (w - a));
            3'd1: r = (d >> a) | (d << (w - a));
            3'd2: r = d << a;
            3'd3: r = d >> a;
            3'd4: begin
                s = d[w-1] ? (d | ~mask) : d;
                r = s >>> a;
            end
            default: return {1'b1, d};
        endcase
        return {1'b0, r & mask};
    endfunction

    task automatic run_op32(input logic [31:0] d, input logic [4:0] a, input logic [2:0] op,
                            output logic [31:0] rd, output logic rz, output logic re,
                            output int lat);
        @(negedge clk);
        a_in_valid  = 1'b1;
        a_in_data   = d;
        a_in_amnt   = a;
        a_in_op     = op;
        a_out_ready = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            a_in_valid = 1'b0;
            lat++;
        end while (!a_out_valid && lat < 20);
        rd = a_out_data;
        rz = a_out_zero;
        re = a_out_err;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_in_valid = 0; a_in_data = '0; a_in_amnt = '0; a_in_op = '0; a_out_ready = 1;
        b_in_valid = 0; b_in_data = '0; b_in_amnt = '0; b_in_op = '0; b_out_ready = 1;
        c_in_valid = 0; c_in_data = '0; c_in_amnt = '0; c_in_op = '0; c_out_ready = 1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({a_out_valid, a_out_data, a_out_zero, a_out_err} !== {1'b0, 32'h0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state32: got valid=%b data=%h zero=%b err=%b required 0/0/1/0",
                     a_out_valid, a_out_data, a_out_zero, a_out_err);
        end
        n_vec++;
        if ({b_out_valid, b_out_zero, c_out_valid, c_out_zero} !== 4'b0101) begin
            n_err++;
            $display("FAIL reset_state8_64: got %b%b%b%b required 0101",
                     b_out_valid, b_out_zero, c_out_valid, c_out_zero);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (a_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_reset: got %b required 1", a_in_ready);
        end
    endtask

    task automatic test_rol();
        logic [31:0] rd; logic rz, re; int lat;
        run_op32(32'h8000_0001, 5'd1, 3'd0, rd, rz, re, lat);
        n_vec++;
        if (rd !== 32'h0000_0003) begin
            n_err++; $display("FAIL rol: got %h required 00000003", rd);
        end
        n_vec++;
        if (lat !== 5) begin
            n_err++; $display("FAIL rol_latency: got %0d required 5", lat);
        end
    endtask

    task automatic test_right_ops();
        logic [2:0]  ops [3] = '{3'd1, 3'd3, 3'd4};
        logic [31:0] exp [3] = '{32'h0800_000F, 32'h0800_000F, 32'hF800_000F};
        logic [31:0] rd; logic rz, re; int lat;
        for (int i = 0; i < 3; i++) begin
            run_op32(32'h8000_00F0, 5'd4, ops[i], rd, rz, re, lat);
            n_vec++;
            if (rd !== exp[i] || lat !== 5) begin
                n_err++;
                $display("FAIL right_op%0d: got %h lat %0d required %h lat 5", ops[i], rd, lat, exp[i]);
            end
        end
    endtask

    task automatic test_sll_zero();
        logic [31:0] rd; logic rz, re; int lat;
        run_op32(32'h0000_0001, 5'd31, 3'd2, rd, rz, re, lat);
        n_vec++;
        if (rd !== 32'h8000_0000 || rz !== 1'b0) begin
            n_err++; $display("FAIL sll31: got %h zero=%b required 80000000 zero=0", rd, rz);
        end
        run_op32(32'h8000_0000, 5'd1, 3'd2, rd, rz, re, lat);
        n_vec++;
        if (rd !== 32'h0 || rz !== 1'b1) begin
            n_err++; $display("FAIL sll_to_zero: got %h zero=%b required 00000000 zero=1", rd, rz);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] rd, d; logic rz, re; int lat;
        run_op32(32'h1234_5678, 5'd9, 3'd6, rd, rz, re, lat);
        n_vec++;
        if (rd !== 32'h1234_5678 || re !== 1'b1 || lat !== 5) begin
            n_err++;
            $display("FAIL illegal6: got %h err=%b lat %0d required 12345678 err=1 lat 5", rd, re, lat);
        end
        for (int op = 5; op <= 7; op += 2) begin
            d = $urandom;
            run_op32(d, 5'($urandom), 3'(op), rd, rz, re, lat);
            n_vec++;
            if (rd !== d || re !== 1'b1) begin
                n_err++; $display("FAIL illegal%0d: got %h err=%b required %h err=1", op, rd, re, d);
            end
        end
        run_op32(32'hDEAD_BEEF, 5'd0, 3'd4, rd, rz, re, lat);
        n_vec++;
        if (rd !== 32'hDEAD_BEEF || re !== 1'b0) begin
            n_err++; $display("FAIL amnt0_sra: got %h err=%b required deadbeef err=0", rd, re);
        end
    endtask

    task automatic test_back_to_back_stall();
        logic [31:0] d [8];
        logic [4:0]  am [8];
        logic [2:0]  op [8];
        logic [31:0] exp [8];
        logic [31:0] held;
        int k = 0, got = 0, extra = 0;
        bit saw_block = 0;
        for (int i = 0; i < 8; i++) begin
            d[i]  = $urandom;
            am[i] = 5'($urandom);
            op[i] = 3'($urandom_range(0, 4));
            exp[i] = ref_op({32'h0, d[i]}, int'(am[i]), op[i], 32) >> 0;
        end
        held = '0;
        for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
            @(negedge clk);
            a_out_ready = !(cyc >= 6 && cyc < 10);
            a_in_valid  = (k < 8);
            if (k < 8) begin
                a_in_data = d[k]; a_in_amnt = am[k]; a_in_op = op[k];
            end
            #1;
            if (cyc == 6) held = a_out_data;
            if (cyc >= 6 && cyc < 10 && !a_in_ready) saw_block = 1;
            if (cyc >= 7 && cyc < 10) begin
                n_vec++;
                if (a_out_data !== held || a_out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL stall_hold c%0d: got %h valid=%b required %h valid=1",
                             cyc, a_out_data, a_out_valid, held);
                end
            end
            if (a_out_valid && a_out_ready) begin
                n_vec++;
                if (a_out_data !== exp[got]) begin
                    n_err++;
                    $display("FAIL b2b_result%0d: got %h required %h", got, a_out_data, exp[got]);
                end
                got++;
            end
            if (a_in_valid && a_in_ready) k++;
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (a_out_valid) extra++;
        end
        n_vec++;
        if (got !== 8 || extra !== 0) begin
            n_err++; $display("FAIL b2b_count: got %0d results %0d extra required 8 and 0", got, extra);
        end
        n_vec++;
        if (saw_block !== 1'b1) begin
            n_err++; $display("FAIL stall_ready: in_ready never dropped, required a drop");
        end
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_in_valid = 1'b1; a_in_data = $urandom; a_in_amnt = 5'($urandom); a_in_op = 3'(i);
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (a_out_valid !== 1'b0 || a_out_zero !== 1'b1) begin
            n_err++; $display("FAIL midreset_clear: got valid=%b zero=%b required 0/1", a_out_valid, a_out_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (a_in_ready !== 1'b1) begin
            n_err++; $display("FAIL midreset_ready: got %b required 1", a_in_ready);
        end
        repeat (10) begin
            @(negedge clk);
            if (a_out_valid) seen++;
        end
        n_vec++;
        if (seen !== 0) begin
            n_err++; $display("FAIL midreset_discard: got %0d outputs required 0", seen);
        end
    endtask

    task automatic test_random();
        logic [64:0] qb[$], qc[$];
        logic [64:0] e;
        int ib = 0, ic = 0;
        for (int cyc = 0; cyc < 6000 && (ib < 64 || ic < 512 || qb.size() > 0 || qc.size() > 0); cyc++) begin
            @(negedge clk);
            b_out_ready = ($urandom_range(0, 3) != 0);
            c_out_ready = ($urandom_range(0, 3) != 0);
            b_in_valid  = (ib < 64) && ($urandom_range(0, 3) != 0);
            c_in_valid  = (ic < 512) && ($urandom_range(0, 3) != 0);
            b_in_data = 8'($urandom);  b_in_amnt = 3'(ib % 8);  b_in_op = 3'(ib / 8);
            c_in_data = {$urandom, $urandom};  c_in_amnt = 6'(ic % 64);  c_in_op = 3'(ic / 64);
            #1;
            if (b_out_valid && b_out_ready) begin
                n_vec++;
                e = (qb.size() > 0) ? qb.pop_front() : 65'h1_DEAD_BEEF_DEAD_BEEF;
                if ({b_out_err, b_out_data} !== {e[64], e[7:0]} || b_out_zero !== (e[7:0] == 8'h0)) begin
                    n_err++;
                    $display("FAIL rand8: got err=%b data=%h zero=%b required err=%b data=%h",
                             b_out_err, b_out_data, b_out_zero, e[64], e[7:0]);
                end
            end
            if (c_out_valid && c_out_ready) begin
                n_vec++;
                e = (qc.size() > 0) ? qc.pop_front() : 65'h1_DEAD_BEEF_DEAD_BEEF;
                if ({c_out_err, c_out_data} !== e || c_out_zero !== (e[63:0] == 64'h0)) begin
                    n_err++;
                    $display("FAIL rand64: got err=%b data=%h zero=%b required err=%b data=%h",
                             c_out_err, c_out_data, c_out_zero, e[64], e[63:0]);
                end
            end
            if (b_in_valid && b_in_ready) begin
                qb.push_back(ref_op({56'h0, b_in_data}, int'(b_in_amnt), b_in_op, 8));
                ib++;
            end
            if (c_in_valid && c_in_ready) begin
                qc.push_back(ref_op(c_in_data, int'(c_in_amnt), c_in_op, 64));
                ic++;
            end
        end
        @(negedge clk);
        b_in_valid = 1'b0;
        c_in_valid = 1'b0;
        n_vec++;
        if (ib !== 64 || ic !== 512 || qb.size() !== 0 || qc.size() !== 0) begin
            n_err++;
            $display("FAIL rand_drain: got %0d/%0d issued %0d/%0d pending required 64/512 issued 0/0 pending",
                     ib, ic, qb.size(), qc.size());
        end
    endtask

    initial begin
        test_reset();
        test_rol();
        test_right_ops();
        test_sll_zero();
        test_illegal();
        test_back_to_back_stall();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/barrel_shifter_pipe.md
BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, data width; a power of two, minimum 8.
REQ-002 SHALL derive SHW = log2(WIDTH), the shift-amount width and the pipeline depth.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL provide port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL provide port in_valid, input, 1 bit: an input operation is presented.
REQ-006 SHALL provide port in_ready, output, 1 bit: the block accepts the presented operation this cycle.
REQ-007 SHALL provide port in_data, input, WIDTH bits: the operand.
REQ-008 SHALL provide port in_amnt, input, SHW bits: the shift amount, 0..WIDTH-1.
REQ-009 SHALL provide port in_op, input, 3 bits: the operation code (REQ-015).
REQ-010 SHALL provide port out_valid, output, 1 bit: a result is presented.
REQ-011 SHALL provide port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL provide port out_data, output, WIDTH bits: the result.
REQ-013 SHALL provide port out_zero, output, 1 bit: out_data is all zeros.
REQ-014 SHALL provide port out_err, output, 1 bit: the operation used an illegal op code.

Function
REQ-015 SHALL encode operations as: 0 ROL, 1 ROR, 2 SLL (zero fill), 3 SRL (zero fill), 4 SRA (sign fill); codes 5-7 are illegal.
REQ-016 SHALL implement SHW stages; stage k shifts by 2^k when in_amnt[k] = 1, otherwise passes its input through.
REQ-017 SHALL register the output of every stage, giving a latency of exactly SHW cycles from acceptance to out_valid (5 cycles at WIDTH = 32).
REQ-018 SHALL carry the valid, op, remaining amount bits and error flag through each stage alongside the data.
REQ-019 SHALL perform right operations by bit-reversing the operand at entry and the result at exit, so that one left-direction core serves all operations; for SRA the fill bit is in_data[WIDTH-1], captured at entry.
REQ-020 SHALL accept an operation when in_valid and in_ready are both 1; in_ready = !out_valid | out_ready.
REQ-021 SHALL stall every stage, holding all data, when out_valid = 1 and out_ready = 0; out_data, out_zero and out_err SHALL hold stable while stalled.
REQ-022 SHALL sustain one accepted operation per cycle when out_ready is held at 1.
REQ-023 SHALL insert bubbles (stage valid = 0) for cycles without an accepted operation; a bubble SHALL never raise out_valid.
REQ-024 SHALL pass in_data unchanged when in_amnt = 0, for every legal op.
REQ-025 SHALL, for an illegal op, output in_data unchanged with out_err = 1, taking the same latency.
REQ-026 SHALL compute out_zero combinationally from the final stage register.

Reset
REQ-027 SHALL, while rst_n = 0, clear all stage valid bits, data, op and flag registers, so that out_valid = 0, out_data = 0, out_zero = 1 and out_err = 0.
REQ-028 SHALL discard every in-flight operation when reset asserts mid-operation; none is output after release.
REQ-029 SHALL drive in_ready = 1 from the first cycle after rst_n deasserts.

Structure
REQ-030 SHALL place the op-code constants and the enumerated op type in a shared package, barrel_pkg.
REQ-031 SHALL implement one stage as a sub-module, barrel_stage, parametrised by WIDTH and stage index, and instantiate it SHW times with a generate loop.

Verification
REQ-032 SHALL check ROL: in_data = 0x8000_0001, amnt = 1, op = 0 -> out_data = 0x0000_0003, 5 cycles after acceptance.
REQ-033 SHALL check ROR, SRL and SRA: in_data = 0x8000_00F0, amnt = 4 -> ROR 0x0800_000F, SRL 0x0800_000F, SRA 0xF800_000F.
REQ-034 SHALL check SLL and out_zero: in_data = 0x0000_0001, amnt = 31, op = 2 -> 0x8000_0000, out_zero = 0; then in_data = 0x8000_0000, amnt = 1 -> 0x0000_0000, out_zero = 1.
REQ-035 SHALL check throughput and stall: 8 back-to-back ops with out_ready held at 0 from cycle 6 -> in_ready drops, out_data holds; on release, all 8 results emerge in order with none lost or duplicated.
REQ-036 SHALL check reset mid-operation and illegal op: op = 6, in_data = 0x1234_5678 -> same data out with out_err = 1; rst_n pulsed low with 3 ops in flight -> no out_valid after release.
REQ-037 SHALL run a random regression at WIDTH = 8 and WIDTH = 64 against a reference model, covering every op and every amount.
